// File: rtl/datapath_unit.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_unit
//  Description : Accumulator-CPU execution datapath: accumulator, add/sub ALU,
//                operand sign-extension, operand muxes, data RAM, halt latch
//                and saturating executed-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module datapath_unit #(
    parameter int BITS    = 16,
    parameter int DTBITS  = BITS - 5,
    parameter int CNTBITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DTBITS-1:0]  i_Data,
    input  logic [1:0]         sel_A,
    input  logic               sel_B,
    input  logic               o_op,
    input  logic               w_acc,
    input  logic               w_ram,
    input  logic               r_ram,
    input  logic               h_flg,
    output logic [BITS-1:0]    o_acc,
    output logic               o_zero,
    output logic               o_neg,
    output logic               o_ovf,
    output logic               o_halted,
    output logic [CNTBITS-1:0] o_icount
);

    localparam int          c_DEPTH   = 2 ** DTBITS;
    localparam logic [1:0]  c_SRC_RAM = 2'b00;
    localparam logic [1:0]  c_SRC_IMM = 2'b01;
    localparam logic [1:0]  c_SRC_ALU = 2'b10;

    logic [BITS-1:0]    r_acc;
    logic               r_ovf;
    logic               r_halted;
    logic [CNTBITS-1:0] r_icount;
    logic [BITS-1:0]    r_mem [0:c_DEPTH-1];

    logic [BITS-1:0]    w_rdata;
    logic [BITS-1:0]    w_sext;
    logic [BITS-1:0]    w_alu_b;
    logic [BITS-1:0]    w_alu_res;
    logic               w_ovf_next;
    logic               w_frozen;
    logic [BITS-1:0]    w_acc_next;
    logic               w_acc_load;
    logic               w_ovf_load;
    logic               w_mem_we;

    // Asynchronous read; a same-cycle write lands at the edge, so reads see old data.
    assign w_rdata   = r_ram ? r_mem[i_Data] : '0;
    assign w_sext    = {{(BITS - DTBITS){i_Data[DTBITS-1]}}, i_Data};
    assign w_alu_b   = sel_B ? w_sext : w_rdata;
    assign w_alu_res = o_op ? (r_acc - w_alu_b) : (r_acc + w_alu_b);

    always_comb begin
        w_ovf_next = 1'b0;
        if (o_op) begin
            w_ovf_next = (r_acc[BITS-1] != w_alu_b[BITS-1]) &&
                         (w_alu_res[BITS-1] != r_acc[BITS-1]);
        end else begin
            w_ovf_next = (r_acc[BITS-1] == w_alu_b[BITS-1]) &&
                         (w_alu_res[BITS-1] != r_acc[BITS-1]);
        end
    end

    assign w_frozen = r_halted | h_flg;

    always_comb begin
        w_acc_next = r_acc;
        case (sel_A)
            c_SRC_RAM: w_acc_next = w_rdata;
            c_SRC_IMM: w_acc_next = w_sext;
            c_SRC_ALU: w_acc_next = w_alu_res;
            default:   w_acc_next = r_acc;
        endcase
    end

    assign w_acc_load = w_acc & ~w_frozen;
    assign w_ovf_load = w_acc_load & (sel_A == c_SRC_ALU);
    assign w_mem_we   = w_ram & ~w_frozen & i_rst;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_halted <= 1'b0;
            r_icount <= '0;
        end else begin
            if (w_acc_load) begin
                r_acc <= w_acc_next;
            end
            if (w_ovf_load) begin
                r_ovf <= w_ovf_next;
            end
            if (h_flg) begin
                r_halted <= 1'b1;
            end
            // The halt instruction itself is counted; nothing after it is.
            if (!r_halted && (r_icount != {CNTBITS{1'b1}})) begin
                r_icount <= r_icount + CNTBITS'(1);
            end
        end
    end

    // Storage is deliberately left out of reset; it captures acc as it was before the edge.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[i_Data] <= r_acc;
        end
    end

    assign o_acc    = r_acc;
    assign o_zero   = (r_acc == '0);
    assign o_neg    = r_acc[BITS-1];
    assign o_ovf    = r_ovf;
    assign o_halted = r_halted;
    assign o_icount = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_datapath_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_unit
//  Description : Self-checking bench for datapath_unit against an integer
//                reference model; a second instance checks counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datapath_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] data;
    logic [1:0]  sel_a;
    logic        sel_b, op, wacc, wram, rram, hflg;

    logic [15:0] acc1, acc2;
    logic        zero1, neg1, ovf1, halted1;
    logic        zero2, neg2, ovf2, halted2;
    logic [15:0] icnt1;
    logic [3:0]  icnt2;

    int n_vec = 0;
    int n_err = 0;

    int m_acc, m_ovf, m_halted, m_cnt;
    int m_mem [2048];

    always #5 clk = ~clk;

    datapath_unit #(.BITS(16), .CNTBITS(16)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_Data(data), .sel_A(sel_a), .sel_B(sel_b),
        .o_op(op), .w_acc(wacc), .w_ram(wram), .r_ram(rram), .h_flg(hflg),
        .o_acc(acc1), .o_zero(zero1), .o_neg(neg1), .o_ovf(ovf1),
        .o_halted(halted1), .o_icount(icnt1)
    );

    datapath_unit #(.BITS(16), .CNTBITS(4)) u_dut_sat (
        .i_clk(clk), .i_rst(rst_n), .i_Data(data), .sel_A(sel_a), .sel_B(sel_b),
        .o_op(op), .w_acc(wacc), .w_ram(wram), .r_ram(rram), .h_flg(hflg),
        .o_acc(acc2), .o_zero(zero2), .o_neg(neg2), .o_ovf(ovf2),
        .o_halted(halted2), .o_icount(icnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, ".acc"},    32'(acc1),    32'(m_acc));
        check_eq({tag, ".zero"},   32'(zero1),   32'(m_acc == 0));
        check_eq({tag, ".neg"},    32'(neg1),    32'(m_acc >= 32768));
        check_eq({tag, ".ovf"},    32'(ovf1),    32'(m_ovf));
        check_eq({tag, ".halted"}, 32'(halted1), 32'(m_halted));
        check_eq({tag, ".icnt"},   32'(icnt1),   32'((m_cnt > 65535) ? 65535 : m_cnt));
        check_eq({tag, ".icnt4"},  32'(icnt2),   32'((m_cnt > 15) ? 15 : m_cnt));
    endtask

    // One instruction: drive at posedge+1, model the edge, compare at next posedge+1.
    task automatic instr(input string tag, input int d, input int sa, input int sb,
                         input int o, input int wa, input int wr, input int rr, input int h);
        int rd, sxi, bi, ri, old, ovfn;
        data  = 11'(d);
        sel_a = 2'(sa);
        sel_b = 1'(sb);
        op    = 1'(o);
        wacc  = 1'(wa);
        wram  = 1'(wr);
        rram  = 1'(rr);
        hflg  = 1'(h);
        rd   = (rr != 0) ? m_mem[d] : 0;
        sxi  = (d >= 1024) ? d - 2048 : d;
        bi   = (sb != 0) ? sxi : to_signed16(rd);
        ri   = (o != 0) ? to_signed16(m_acc) - bi : to_signed16(m_acc) + bi;
        ovfn = (ri > 32767 || ri < -32768) ? 1 : 0;
        old  = m_acc;
        @(posedge clk);
        if (m_halted == 0) begin
            m_cnt++;
            if (h != 0) begin
                m_halted = 1;
            end else begin
                if (wa != 0) begin
                    if (sa == 0) m_acc = rd;
                    else if (sa == 1) m_acc = sxi & 16'hFFFF;
                    else if (sa == 2) m_acc = ri & 16'hFFFF;
                    if (sa == 2) m_ovf = ovfn;
                end
                if (wr != 0) m_mem[d] = old;
            end
        end
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data  = 11'($urandom_range(0, 2047));
        sel_a = 2'($urandom_range(0, 3));
        sel_b = 1'($urandom_range(0, 1));
        op    = 1'($urandom_range(0, 1));
        wacc  = 1'($urandom_range(0, 1));
        wram  = 1'($urandom_range(0, 1));
        rram  = 1'($urandom_range(0, 1));
        hflg  = 1'($urandom_range(0, 1));
        m_acc = 0; m_ovf = 0; m_halted = 0; m_cnt = 0;
        #1;
        compare_all("reset_async");
        wram = 1'b0;
        @(posedge clk);
        #1;
        compare_all("reset_held");
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        data = '0; sel_a = '0; sel_b = 0; op = 0; wacc = 0; wram = 0; rram = 0; hflg = 0;
        m_acc = 0; m_ovf = 0; m_halted = 0; m_cnt = 0;
        for (int i = 0; i < 2048; i++) m_mem[i] = 0;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("rst.acc", 32'(acc1), 32'h0);
        check_eq("rst.zero", 32'(zero1), 32'h1);

        // Load immediate, store, reload, gated read.
        instr("t2_ldi", 11'h7FF, 1, 0, 0, 1, 0, 0, 0);
        check_eq("t2.acc_ffff", 32'(acc1), 32'hFFFF);
        check_eq("t2.neg", 32'(neg1), 32'h1);
        instr("t2_st5", 5, 0, 0, 0, 0, 1, 0, 0);
        instr("t2_ld0", 0, 1, 0, 0, 1, 0, 0, 0);
        instr("t2_ld5", 5, 0, 0, 0, 1, 0, 1, 0);
        check_eq("t2.reload", 32'(acc1), 32'hFFFF);
        instr("t2_gated", 5, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t2.gated", 32'(acc1), 32'h0);

        // Build 0x7FFF with additions, then cross both overflow boundaries.
        instr("t3_ld0", 0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 32; i++) instr("t3_add", 1023, 2, 1, 0, 1, 0, 0, 0);
        instr("t3_add31", 31, 2, 1, 0, 1, 0, 0, 0);
        check_eq("t3.max", 32'(acc1), 32'h7FFF);
        instr("t3_addovf", 1, 2, 1, 0, 1, 0, 0, 0);
        check_eq("t3.add_acc", 32'(acc1), 32'h8000);
        check_eq("t3.add_ovf", 32'(ovf1), 32'h1);
        instr("t3_subovf", 1, 2, 1, 1, 1, 0, 0, 0);
        check_eq("t3.sub_acc", 32'(acc1), 32'h7FFF);
        check_eq("t3.sub_ovf", 32'(ovf1), 32'h1);
        instr("t3_ld5", 5, 1, 0, 0, 1, 0, 0, 0);
        instr("t3_sub5", 5, 2, 1, 1, 1, 0, 0, 0);
        check_eq("t3.zero", 32'(zero1), 32'h1);
        check_eq("t3.ovf_clr", 32'(ovf1), 32'h0);

        // Simultaneous acc and RAM write, then same-address read-during-write.
        instr("t4_ld3", 3, 1, 0, 0, 1, 0, 0, 0);
        instr("t4_both", 9, 1, 0, 0, 1, 1, 0, 0);
        check_eq("t4.acc", 32'(acc1), 32'h9);
        instr("t4_rdw", 9, 0, 0, 0, 1, 1, 1, 0);
        check_eq("t4.ram_old", 32'(acc1), 32'h3);
        instr("t4_rd", 9, 0, 0, 0, 1, 0, 1, 0);
        check_eq("t4.ram_new", 32'(acc1), 32'h9);

        // Fill the whole RAM so random reads have defined contents.
        for (int a = 0; a < 2048; a++) instr("fill", a, 1, 0, 0, 1, 1, 0, 0);

        for (int k = 0; k < 400; k++) begin
            instr("rand", $urandom_range(0, 2047), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 0);
        end

        // Halt: counted, suppresses its own writes, then freezes everything.
        do_reset();
        instr("t5_i1", 7, 1, 0, 0, 1, 0, 0, 0);
        instr("t5_i2", 3, 2, 1, 0, 1, 0, 0, 0);
        instr("t5_i3", 4, 0, 0, 0, 0, 1, 0, 0);
        instr("t5_i4", 2, 2, 1, 1, 1, 0, 0, 0);
        instr("t5_halt", 100, 1, 0, 0, 1, 1, 0, 1);
        check_eq("t5.halted", 32'(halted1), 32'h1);
        check_eq("t5.acc", 32'(acc1), 32'h8);
        check_eq("t5.icnt", 32'(icnt1), 32'h5);
        for (int k = 0; k < 12; k++) begin
            instr("t5_frozen", $urandom_range(0, 2047), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 1,
                  $urandom_range(0, 1));
        end
        check_eq("t5.icnt_held", 32'(icnt1), 32'h5);
        do_reset();
        check_eq("t5.rst_halted", 32'(halted1), 32'h0);
        instr("t5_ram100", 100, 0, 0, 0, 1, 0, 1, 0);
        instr("t5_ram4", 4, 0, 0, 0, 1, 0, 1, 0);
        check_eq("t5.ram4", 32'(acc1), 32'hA);

        // Saturation of the narrow counter.
        do_reset();
        for (int k = 0; k < 20; k++) instr("t6_run", k, 1, 0, 0, 1, 0, 0, 0);
        check_eq("t6.sat4", 32'(icnt2), 32'hF);
        check_eq("t6.cnt16", 32'(icnt1), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
